// File: rtl/memory_controller_responder_if.sv
// Request/response channel bundle between a hart's load/store units and the memory responder.
// master = hart side, slave = memory controller side.
interface memory_controller_responder_if;
    logic        hart_to_memory_controller_valid;
    logic [31:0] hart_to_memory_controller_address;
    logic        hart_to_memory_controller_write;
    logic [31:0] hart_to_memory_controller_write_data;
    logic        hart_to_memory_controller_ready;
    logic        memory_controller_to_hart_ready;
    logic        memory_controller_to_hart_valid;
    logic [31:0] memory_controller_to_hart_read_data;
    logic        memory_controller_to_hart_error;

    modport master (
        output hart_to_memory_controller_valid,
        output hart_to_memory_controller_address,
        output hart_to_memory_controller_write,
        output hart_to_memory_controller_write_data,
        input  hart_to_memory_controller_ready,
        output memory_controller_to_hart_ready,
        input  memory_controller_to_hart_valid,
        input  memory_controller_to_hart_read_data,
        input  memory_controller_to_hart_error
    );

    modport slave (
        input  hart_to_memory_controller_valid,
        input  hart_to_memory_controller_address,
        input  hart_to_memory_controller_write,
        input  hart_to_memory_controller_write_data,
        output hart_to_memory_controller_ready,
        input  memory_controller_to_hart_ready,
        output memory_controller_to_hart_valid,
        output memory_controller_to_hart_read_data,
        output memory_controller_to_hart_error
    );
endinterface

// File: rtl/memory_controller_responder.sv
// Single-outstanding memory responder backed by a word-addressed synchronous RAM.
// Optional sticky first-fault capture: define MEMORY_CONTROLLER_FAULT_CAPTURE_EN.
module memory_controller_responder #(
    parameter int unsigned WORDS     = 1024,
    parameter int unsigned INIT_ZERO = 1
) (
    input  logic clock,
    input  logic clear,
    memory_controller_responder_if.slave bus
`ifdef MEMORY_CONTROLLER_FAULT_CAPTURE_EN
    ,
    output logic        fault_valid,
    output logic [31:0] fault_address
`endif
);
    localparam int unsigned IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCESS  = 2'd1,
        ST_RESPOND = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic        req_ready_q, req_ready_d;
    logic        resp_valid_q, resp_valid_d;
    logic [31:0] resp_data_q, resp_data_d;
    logic        resp_error_q, resp_error_d;
    logic        write_q, write_d;
    logic        err_q, err_d;

    logic             req_fire_s;
    logic             req_err_s;
    logic             ram_we_s;
    logic             ram_re_s;
    logic [IDX_W-1:0] ram_idx_s;
    logic [31:0]      ram_rdata_s;

    assign req_fire_s = bus.hart_to_memory_controller_valid & req_ready_q;
    assign req_err_s  = (bus.hart_to_memory_controller_address[1:0] != 2'b00) |
                        ({2'b00, bus.hart_to_memory_controller_address[31:2]} >= 32'(WORDS));
    assign ram_idx_s  = bus.hart_to_memory_controller_address[IDX_W+1:2];

    // RAM is addressed straight from the request inputs in the handshake cycle.
    generate
        if (INIT_ZERO != 0) begin : g_ram_zero
            logic [31:0] mem_q [WORDS] = '{default: 32'h0000_0000};
            logic [31:0] rdata_q;

            // Synchronous single-port RAM with power-up zero contents.
            always_ff @(posedge clock) begin
                if (ram_we_s) begin
                    mem_q[ram_idx_s] <= bus.hart_to_memory_controller_write_data;
                end
                if (ram_re_s) begin
                    rdata_q <= mem_q[ram_idx_s];
                end
            end
            assign ram_rdata_s = rdata_q;
        end else begin : g_ram_raw
            logic [31:0] mem_q [WORDS];
            logic [31:0] rdata_q;

            // Synchronous single-port RAM with undefined power-up contents.
            always_ff @(posedge clock) begin
                if (ram_we_s) begin
                    mem_q[ram_idx_s] <= bus.hart_to_memory_controller_write_data;
                end
                if (ram_re_s) begin
                    rdata_q <= mem_q[ram_idx_s];
                end
            end
            assign ram_rdata_s = rdata_q;
        end
    endgenerate

    // Next-state and response computation; outputs are registered from these values.
    always_comb begin
        state_d      = state_q;
        req_ready_d  = req_ready_q;
        resp_valid_d = resp_valid_q;
        resp_data_d  = resp_data_q;
        resp_error_d = resp_error_q;
        write_d      = write_q;
        err_d        = err_q;
        ram_we_s     = 1'b0;
        ram_re_s     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req_fire_s) begin
                    write_d     = bus.hart_to_memory_controller_write;
                    err_d       = req_err_s;
                    ram_we_s    = ~req_err_s & bus.hart_to_memory_controller_write;
                    ram_re_s    = ~req_err_s & ~bus.hart_to_memory_controller_write;
                    state_d     = ST_ACCESS;
                    req_ready_d = 1'b0;
                end else begin
                    state_d     = ST_IDLE;
                    req_ready_d = 1'b1;
                end
            end
            ST_ACCESS: begin
                // Writes and rejected requests never expose stale RAM output.
                if (write_q | err_q) begin
                    resp_data_d = 32'h0000_0000;
                end else begin
                    resp_data_d = ram_rdata_s;
                end
                resp_valid_d = 1'b1;
                resp_error_d = err_q;
                state_d      = ST_RESPOND;
                req_ready_d  = 1'b0;
            end
            ST_RESPOND: begin
                if (bus.memory_controller_to_hart_ready) begin
                    resp_valid_d = 1'b0;
                    resp_data_d  = 32'h0000_0000;
                    resp_error_d = 1'b0;
                    state_d      = ST_IDLE;
                    req_ready_d  = 1'b1;
                end else begin
                    state_d      = ST_RESPOND;
                    req_ready_d  = 1'b0;
                end
            end
            default: begin
                resp_valid_d = 1'b0;
                resp_data_d  = 32'h0000_0000;
                resp_error_d = 1'b0;
                state_d      = ST_IDLE;
                req_ready_d  = 1'b1;
            end
        endcase
    end

    // State and response registers; clear drops any in-flight response.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state_q      <= ST_IDLE;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_data_q  <= 32'h0000_0000;
            resp_error_q <= 1'b0;
            write_q      <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            resp_error_q <= resp_error_d;
            write_q      <= write_d;
            err_q        <= err_d;
        end
    end

    assign bus.hart_to_memory_controller_ready     = req_ready_q;
    assign bus.memory_controller_to_hart_valid     = resp_valid_q;
    assign bus.memory_controller_to_hart_read_data = resp_data_q;
    assign bus.memory_controller_to_hart_error     = resp_error_q;

`ifdef MEMORY_CONTROLLER_FAULT_CAPTURE_EN
    logic        fault_valid_q;
    logic [31:0] fault_address_q;

    // Sticky capture of the first rejected request address.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            fault_valid_q   <= 1'b0;
            fault_address_q <= 32'h0000_0000;
        end else if (req_fire_s && req_err_s && !fault_valid_q) begin
            fault_valid_q   <= 1'b1;
            fault_address_q <= bus.hart_to_memory_controller_address;
        end else begin
            fault_valid_q   <= fault_valid_q;
            fault_address_q <= fault_address_q;
        end
    end

    assign fault_valid   = fault_valid_q;
    assign fault_address = fault_address_q;
`endif
endmodule

// File: tb/tb_memory_controller_responder.sv
// Directed plus randomized bench for memory_controller_responder against a word-array model.
module tb_memory_controller_responder;
    localparam int unsigned WORDS = 1024;

    logic clock = 1'b0;
    logic clear;

    memory_controller_responder_if bus();

`ifdef MEMORY_CONTROLLER_FAULT_CAPTURE_EN
    logic        fault_valid;
    logic [31:0] fault_address;
`endif

    memory_controller_responder #(.WORDS(WORDS), .INIT_ZERO(1)) dut (
        .clock(clock),
        .clear(clear),
        .bus(bus)
`ifdef MEMORY_CONTROLLER_FAULT_CAPTURE_EN
        ,
        .fault_valid(fault_valid),
        .fault_address(fault_address)
`endif
    );

    always #5 clock = ~clock;

    int n_cmp  = 0;
    int n_fail = 0;
    logic [31:0] ref_mem [int];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    function automatic logic ref_err(input logic [31:0] a);
        return ((a % 32'd4) != 32'd0) || (a >= 32'(4 * WORDS));
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        int idx;
        idx = int'(a / 32'd4);
        return ref_mem.exists(idx) ? ref_mem[idx] : 32'h0000_0000;
    endfunction

    // Called at a negedge; returns #1 after the accepting edge with a junk request held on the bus.
    task automatic issue(input logic [31:0] a, input logic w, input logic [31:0] d);
        int n;
        n = 0;
        bus.hart_to_memory_controller_valid      = 1'b1;
        bus.hart_to_memory_controller_address    = a;
        bus.hart_to_memory_controller_write      = w;
        bus.hart_to_memory_controller_write_data = d;
        while (bus.hart_to_memory_controller_ready !== 1'b1 && n < 20) begin
            @(negedge clock);
            n++;
        end
        chk("req_accept_in_time", 32'(n < 20), 32'd1);
        @(posedge clock);
        #1;
        bus.hart_to_memory_controller_address    = 32'h100 + 32'(4 * $urandom_range(0, 15));
        bus.hart_to_memory_controller_write      = 1'b1;
        bus.hart_to_memory_controller_write_data = $urandom;
    endtask

    task automatic respond(input logic [31:0] ed, input logic ee, input int stall, input string tag);
        bus.memory_controller_to_hart_ready = (stall == 0);
        @(negedge clock);
        chk({tag, "_access_valid"}, 32'(bus.memory_controller_to_hart_valid), 32'd0);
        chk({tag, "_access_req_ready"}, 32'(bus.hart_to_memory_controller_ready), 32'd0);
        @(negedge clock);
        chk({tag, "_valid"}, 32'(bus.memory_controller_to_hart_valid), 32'd1);
        chk({tag, "_data"}, bus.memory_controller_to_hart_read_data, ed);
        chk({tag, "_error"}, 32'(bus.memory_controller_to_hart_error), 32'(ee));
        chk({tag, "_busy_req_ready"}, 32'(bus.hart_to_memory_controller_ready), 32'd0);
        for (int i = 2; i <= stall + 1; i++) begin
            @(negedge clock);
            chk({tag, "_hold_valid"}, 32'(bus.memory_controller_to_hart_valid), 32'd1);
            chk({tag, "_hold_data"}, bus.memory_controller_to_hart_read_data, ed);
            chk({tag, "_hold_error"}, 32'(bus.memory_controller_to_hart_error), 32'(ee));
            chk({tag, "_hold_req_ready"}, 32'(bus.hart_to_memory_controller_ready), 32'd0);
        end
        bus.memory_controller_to_hart_ready = 1'b1;
        bus.hart_to_memory_controller_valid = 1'b0;
        @(negedge clock);
        chk({tag, "_done_valid"}, 32'(bus.memory_controller_to_hart_valid), 32'd0);
        chk({tag, "_done_data"}, bus.memory_controller_to_hart_read_data, 32'd0);
        chk({tag, "_done_error"}, 32'(bus.memory_controller_to_hart_error), 32'd0);
        chk({tag, "_done_req_ready"}, 32'(bus.hart_to_memory_controller_ready), 32'd1);
    endtask

    task automatic xact(input logic [31:0] a, input logic w, input logic [31:0] d,
                        input int stall, input string tag);
        logic [31:0] ed;
        logic        ee;
        ee = ref_err(a);
        ed = (ee || w) ? 32'h0000_0000 : ref_rd(a);
        if (!ee && w) begin
            ref_mem[int'(a / 32'd4)] = d;
        end
        @(negedge clock);
        issue(a, w, d);
        respond(ed, ee, stall, tag);
    endtask

    initial begin
        logic [31:0] a;
        int          kind;

        clear = 1'b1;
        bus.hart_to_memory_controller_valid      = 1'b0;
        bus.hart_to_memory_controller_address    = 32'h0;
        bus.hart_to_memory_controller_write      = 1'b0;
        bus.hart_to_memory_controller_write_data = 32'h0;
        bus.memory_controller_to_hart_ready      = 1'b1;
        #12;
        chk("rst_req_ready", 32'(bus.hart_to_memory_controller_ready), 32'd1);
        chk("rst_resp_valid", 32'(bus.memory_controller_to_hart_valid), 32'd0);
        chk("rst_read_data", bus.memory_controller_to_hart_read_data, 32'd0);
        chk("rst_error", 32'(bus.memory_controller_to_hart_error), 32'd0);
        @(negedge clock);
        clear = 1'b0;

        xact(32'h10, 1'b1, 32'hDEADBEEF, 0, "wr10");
        xact(32'h10, 1'b0, 32'h0, 0, "rd10");
        xact(32'h12, 1'b0, 32'h0, 0, "rd_misaligned");
        xact(32'h10, 1'b0, 32'h0, 0, "rd10_again");
        xact(32'h0, 1'b1, 32'hA5A5_5A5A, 0, "wr0");
        xact(32'(4 * WORDS), 1'b1, 32'hFFFFFFFF, 0, "wr_out_of_range");
        xact(32'h0, 1'b0, 32'h0, 0, "rd0_unchanged");
        xact(32'h10, 1'b0, 32'h0, 5, "rd_stall5");
        xact(32'h44, 1'b0, 32'h0, 0, "rd_never_written");
        xact(32'(4 * WORDS - 4), 1'b1, 32'hC001_D00D, 0, "wr_last_word");
        xact(32'(4 * WORDS - 4), 1'b0, 32'h0, 1, "rd_last_word");
        xact(32'hFFFF_FFFC, 1'b0, 32'h0, 0, "rd_far_out");

        // Clear during ACCESS after a write: outputs reset at once, write stays committed.
        @(negedge clock);
        issue(32'h20, 1'b1, 32'h12345678);
        ref_mem[8] = 32'h12345678;
        bus.hart_to_memory_controller_valid = 1'b0;
        @(negedge clock);
        clear = 1'b1;
        #1;
        chk("clr_req_ready", 32'(bus.hart_to_memory_controller_ready), 32'd1);
        chk("clr_resp_valid", 32'(bus.memory_controller_to_hart_valid), 32'd0);
        chk("clr_read_data", bus.memory_controller_to_hart_read_data, 32'd0);
        chk("clr_error", 32'(bus.memory_controller_to_hart_error), 32'd0);
        @(negedge clock);
        chk("clr_held_resp_valid", 32'(bus.memory_controller_to_hart_valid), 32'd0);
        clear = 1'b0;
        xact(32'h20, 1'b0, 32'h0, 0, "rd20_after_clear");

        for (int t = 0; t < 40; t++) begin
            kind = int'($urandom_range(0, 19));
            if (kind < 14) begin
                a = 32'h100 + 32'(4 * $urandom_range(0, 15));
            end else if (kind < 17) begin
                a = 32'h100 + 32'($urandom_range(0, 63)) | 32'h1;
            end else begin
                a = 32'(4 * WORDS) + 32'(4 * $urandom_range(0, 1000));
            end
            xact(a, 1'($urandom_range(0, 1)), $urandom, int'($urandom_range(0, 3)), "rand");
        end

`ifdef MEMORY_CONTROLLER_FAULT_CAPTURE_EN
        @(negedge clock);
        clear = 1'b1;
        @(negedge clock);
        clear = 1'b0;
        chk("fault_valid_reset", 32'(fault_valid), 32'd0);
        chk("fault_address_reset", fault_address, 32'd0);
        xact(32'h3, 1'b0, 32'h0, 0, "fault_rd3");
        xact(32'h7, 1'b1, 32'h1111_2222, 0, "fault_wr7");
        chk("fault_valid_set", 32'(fault_valid), 32'd1);
        chk("fault_address_first", fault_address, 32'h3);
        @(negedge clock);
        clear = 1'b1;
        #1;
        chk("fault_valid_cleared", 32'(fault_valid), 32'd0);
        chk("fault_address_cleared", fault_address, 32'd0);
        @(negedge clock);
        clear = 1'b0;
`endif

        @(negedge clock);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
